// File: rtl/nonoverlap_clkgen_multi.sv
// rtl/nonoverlap_clkgen_multi.sv - multi-channel phase-shifted clock generator with non-overlapping complements
module nonoverlap_clkgen_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 32,
  parameter int DEF_HIGH   = 16,
  parameter int DEF_DEAD   = 0
) (
  input  logic                   CLK_IN,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic                   LOAD,
  input  logic [CNT_W-1:0]       PERIOD_IN,
  input  logic [N_CH*CNT_W-1:0]  HIGH_IN,
  input  logic [N_CH*CNT_W-1:0]  PHASE_IN,
  input  logic [CNT_W-1:0]       DEAD_IN,
  output logic [N_CH-1:0]        CLK_OUT,
  output logic [N_CH-1:0]        CLK_OUT_N,
  output logic                   SYNC,
  output logic                   CFG_PENDING,
  output logic                   CFG_ERR
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W+1:0] wide_t;

  // Base counter and active (applied) configuration
  cnt_t cnt_q, cnt_d;
  cnt_t per_q, per_d;
  cnt_t dead_q, dead_d;
  cnt_t high_q [N_CH];
  cnt_t high_d [N_CH];
  cnt_t phase_q [N_CH];
  cnt_t phase_d [N_CH];

  // Shadow configuration waiting for the next period boundary
  cnt_t sh_per_q, sh_per_d;
  cnt_t sh_dead_q, sh_dead_d;
  cnt_t sh_high_q [N_CH];
  cnt_t sh_high_d [N_CH];
  cnt_t sh_phase_q [N_CH];
  cnt_t sh_phase_d [N_CH];

  logic pend_q, pend_d;
  logic err_q, err_d;

  logic [N_CH-1:0] out_q, out_d;
  logic [N_CH-1:0] outn_q, outn_d;
  logic            sync_q, sync_d;

  logic  load_ok;
  logic  last;
  logic  apply;
  wide_t p_w [N_CH];

  // Validate the requested configuration against the rules for a glitch-free waveform
  always_comb begin
    load_ok = (PERIOD_IN >= cnt_t'(2));
    for (int i = 0; i < N_CH; i++) begin
      if (PHASE_IN[i*CNT_W +: CNT_W] >= PERIOD_IN) begin
        load_ok = 1'b0;
      end
      if ((wide_t'(HIGH_IN[i*CNT_W +: CNT_W]) + (wide_t'(DEAD_IN) << 1)) > wide_t'(PERIOD_IN)) begin
        load_ok = 1'b0;
      end
    end
  end

  // Per-channel phase position and next registered output values
  always_comb begin
    out_d  = '0;
    outn_d = '0;
    sync_d = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_q >= phase_q[i]) begin
        p_w[i] = wide_t'(cnt_q) - wide_t'(phase_q[i]);
      end else begin
        p_w[i] = wide_t'(cnt_q) + wide_t'(per_q) - wide_t'(phase_q[i]);
      end
      if (ENABLE) begin
        out_d[i]  = (p_w[i] < wide_t'(high_q[i]));
        outn_d[i] = (p_w[i] >= wide_t'(high_q[i]) + wide_t'(dead_q)) &&
                    (p_w[i] + wide_t'(dead_q) < wide_t'(per_q));
      end
    end
    if (ENABLE) begin
      sync_d = (cnt_q == '0);
    end
  end

  // Counter advance, config switchover at the period boundary and shadow capture
  always_comb begin
    last  = (wide_t'(cnt_q) + wide_t'(1) == wide_t'(per_q));
    apply = pend_q && (!ENABLE || last);
    cnt_d = (!ENABLE || last) ? '0 : cnt_q + cnt_t'(1);

    per_d  = apply ? sh_per_q : per_q;
    dead_d = apply ? sh_dead_q : dead_q;
    for (int i = 0; i < N_CH; i++) begin
      high_d[i]  = apply ? sh_high_q[i] : high_q[i];
      phase_d[i] = apply ? sh_phase_q[i] : phase_q[i];
    end

    sh_per_d  = sh_per_q;
    sh_dead_d = sh_dead_q;
    for (int i = 0; i < N_CH; i++) begin
      sh_high_d[i]  = sh_high_q[i];
      sh_phase_d[i] = sh_phase_q[i];
    end
    pend_d = apply ? 1'b0 : pend_q;
    err_d  = err_q;

    // A capture on the wrap edge stays pending for the following wrap
    if (LOAD) begin
      if (load_ok) begin
        sh_per_d  = PERIOD_IN;
        sh_dead_d = DEAD_IN;
        for (int i = 0; i < N_CH; i++) begin
          sh_high_d[i]  = HIGH_IN[i*CNT_W +: CNT_W];
          sh_phase_d[i] = PHASE_IN[i*CNT_W +: CNT_W];
        end
        pend_d = 1'b1;
        err_d  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State register; reset restores the default staggered configuration
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      cnt_q     <= '0;
      per_q     <= cnt_t'(DEF_PERIOD);
      dead_q    <= cnt_t'(DEF_DEAD);
      sh_per_q  <= cnt_t'(DEF_PERIOD);
      sh_dead_q <= cnt_t'(DEF_DEAD);
      for (int i = 0; i < N_CH; i++) begin
        high_q[i]     <= cnt_t'(DEF_HIGH);
        phase_q[i]    <= cnt_t'((i * DEF_PERIOD) / N_CH);
        sh_high_q[i]  <= cnt_t'(DEF_HIGH);
        sh_phase_q[i] <= cnt_t'((i * DEF_PERIOD) / N_CH);
      end
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      out_q  <= '0;
      outn_q <= '0;
      sync_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      dead_q    <= dead_d;
      sh_per_q  <= sh_per_d;
      sh_dead_q <= sh_dead_d;
      for (int i = 0; i < N_CH; i++) begin
        high_q[i]     <= high_d[i];
        phase_q[i]    <= phase_d[i];
        sh_high_q[i]  <= sh_high_d[i];
        sh_phase_q[i] <= sh_phase_d[i];
      end
      pend_q <= pend_d;
      err_q  <= err_d;
      out_q  <= out_d;
      outn_q <= outn_d;
      sync_q <= sync_d;
    end
  end

  assign CLK_OUT     = out_q;
  assign CLK_OUT_N   = outn_q;
  assign SYNC        = sync_q;
  assign CFG_PENDING = pend_q;
  assign CFG_ERR     = err_q;

endmodule
